// File: rtl/lab3_pkg.sv
// lab3_pkg: shared types and constants for the lab3 recorder timer.
//   timer_state_t : timer FSM state, encoded as it appears on o_state
//   SEC_W         : width of the seconds and recorded-length values
//   MODE_REC/PLAY : encoding of the latched run mode
package lab3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam int unsigned SEC_W = 5;

  localparam logic MODE_REC  = 1'b0;
  localparam logic MODE_PLAY = 1'b1;

endpackage

// File: rtl/record_timer_tick_prescaler.sv
// tick_prescaler: divides i_clk down to one wrap strobe every CLK_HZ enabled
// cycles.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   i_en   : count enable; the count is held while low
//   i_clr  : synchronous clear of the count
//   o_tick : high during the enabled cycle in which the count wraps to 0
//            (combinational; the parent registers it)
module tick_prescaler #(
  parameter int unsigned CLK_HZ = 12_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  // Guard against a zero-width counter for degenerate CLK_HZ values.
  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // The wrap edge is the one on which the parent increments its seconds.
  assign o_tick = i_en && (count_r == CNT_LAST);

  // Count 0..CLK_HZ-1 while enabled, hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_r <= '0;
    end else if (i_clr) begin
      count_r <= '0;
    end else if (i_en) begin
      if (count_r == CNT_LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/record_timer.sv
// record_timer: elapsed-seconds timer for the lab3 audio recorder.
// Counts whole seconds while recording or playing, remembers the length of
// the last recording and ends playback automatically at that length.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_start           : pulse; start from IDLE or resume from PAUSED
//   i_pause           : pulse; toggle RUN/PAUSED
//   i_stop            : pulse; end the current run
//   i_mode            : 0 = record, 1 = play; sampled on start from IDLE
//   o_sec             : elapsed seconds (0..MAX_SEC) for the HEX decoder
//   o_rec_len         : length of the last completed recording
//   o_state           : IDLE=0, RUN=1, PAUSED=2, DONE=3
//   o_tick            : one-cycle pulse per second boundary
//   o_done            : one-cycle pulse on entry to DONE
module record_timer
  import lab3_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 12_000_000,
  parameter int unsigned MAX_SEC = 31
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_stop,
  input  logic             i_mode,
  output logic [SEC_W-1:0] o_sec,
  output logic [SEC_W-1:0] o_rec_len,
  output logic [1:0]       o_state,
  output logic             o_tick,
  output logic             o_done
);

  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(MAX_SEC);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

  timer_state_t     state_r;
  logic [SEC_W-1:0] sec_r;
  logic [SEC_W-1:0] rec_len_r;
  logic             mode_r;
  logic             tick_r;
  logic             done_r;

  logic             pre_en_s;
  logic             pre_clr_s;
  logic             wrap_s;
  logic [SEC_W-1:0] sec_inc_s;

  // The prescaler must not advance on the edge that pauses or stops, so the
  // partial second is kept intact across a pause.
  assign pre_en_s  = (state_r == RUN) && !i_stop && !i_pause;
  assign pre_clr_s = (state_r == IDLE) && i_start;
  assign sec_inc_s = sec_r + SEC_ONE;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (pre_en_s),
    .i_clr  (pre_clr_s),
    .o_tick (wrap_s)
  );

  // Timer FSM, seconds counter and recorded-length register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= IDLE;
      sec_r     <= '0;
      rec_len_r <= '0;
      mode_r    <= MODE_REC;
      tick_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      tick_r <= wrap_s;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start) begin
            sec_r  <= '0;
            mode_r <= i_mode;
            // Nothing recorded yet: playback ends before it begins.
            if ((i_mode == MODE_PLAY) && (rec_len_r == '0)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (i_stop) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            if (mode_r == MODE_REC) begin
              rec_len_r <= sec_r;
            end else begin
              rec_len_r <= rec_len_r;
            end
          end else if (i_pause) begin
            state_r <= PAUSED;
          end else if (wrap_s) begin
            if (sec_r == SEC_MAX) begin
              // Saturate: finish instead of wrapping the display to 00.
              state_r <= DONE;
              done_r  <= 1'b1;
              if (mode_r == MODE_REC) begin
                rec_len_r <= sec_r;
              end else begin
                rec_len_r <= rec_len_r;
              end
            end else begin
              sec_r <= sec_inc_s;
              if ((mode_r == MODE_PLAY) && (sec_inc_s == rec_len_r)) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= RUN;
              end
            end
          end else begin
            state_r <= RUN;
          end
        end
        PAUSED: begin
          if (i_stop) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            if (mode_r == MODE_REC) begin
              rec_len_r <= sec_r;
            end else begin
              rec_len_r <= rec_len_r;
            end
          end else if (i_start || i_pause) begin
            state_r <= RUN;
          end else begin
            state_r <= PAUSED;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_sec     = sec_r;
  assign o_rec_len = rec_len_r;
  assign o_state   = state_r;
  assign o_tick    = tick_r;
  assign o_done    = done_r;

endmodule

// File: doc/record_timer.md
Name: record_timer

Overview:
- Elapsed-seconds timer for the lab3 audio recorder; counts whole seconds while recording or playing.
- Drives the 5-bit seconds value into the two-digit seven-segment decoder, which shows 00..31 on HEX.
- Latches the recorded length so playback stops automatically at the end of the recording.
- Sits between the key/command debouncer (upstream) and the HEX display decoder (downstream).

Parameters:
- CLK_HZ, 12_000_000, system clock frequency; one tick every CLK_HZ cycles.
- MAX_SEC, 31, saturation limit; must fit in 5 bits.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, asynchronous, active-high
- i_start  input  1  one-cycle pulse; start from IDLE, or resume from PAUSED
- i_pause  input  1  one-cycle pulse; toggle RUN/PAUSED
- i_stop  input  1  one-cycle pulse; end current run
- i_mode  input  1  0 = record, 1 = play; sampled only on start from IDLE
- o_sec  output  5  elapsed whole seconds, to display decoder
- o_rec_len  output  5  length of last completed recording
- o_state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3
- o_tick  output  1  one-cycle pulse on each second boundary
- o_done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, o_sec=0, o_rec_len=0, prescaler=0, o_tick=0, o_done=0, latched mode=record.
- Command priority when pulses coincide: stop > start > pause.
- All outputs are registered. A command sampled at edge N changes o_state at edge N.
- Prescaler counts 0..CLK_HZ-1 and runs only in RUN. Its width is $clog2(CLK_HZ).
- Prescaler wrap: when it reaches CLK_HZ-1, it wraps to 0 on the next edge, o_tick is asserted for that one cycle, and o_sec increments.
- IDLE:
  - start -> RUN; o_sec<=0, prescaler<=0, latch i_mode.
  - pause and stop are ignored.
- IDLE start in play mode with o_rec_len==0 -> DONE directly, with no RUN cycle.
- RUN:
  - pause -> PAUSED; prescaler frozen, o_sec held.
  - stop -> DONE.
  - start is ignored.
- RUN, record mode:
  - If a tick would take o_sec past MAX_SEC, go to DONE instead. o_sec stays MAX_SEC and o_tick still pulses.
  - On any entry to DONE from record mode, o_rec_len<=o_sec (value after any same-cycle increment).
- RUN, play mode:
  - When a tick makes o_sec equal to o_rec_len -> DONE on the same edge.
  - o_rec_len is unchanged.
- PAUSED:
  - start or pause -> RUN; prescaler resumes from its held value, with no lost partial second.
  - stop -> DONE.
- DONE: o_done=1 for exactly this one cycle. Unconditionally -> IDLE next edge. Commands during DONE are ignored.
- o_sec keeps its final value in DONE and IDLE until the next start, so the display keeps showing the final time.
- Reset mid-run: everything returns to reset values immediately, including o_rec_len, and no o_done is issued.
- Width rule: o_sec never exceeds MAX_SEC and never wraps to 0.

Decomposition:
- Package lab3_pkg:
  - timer_state_t enum (IDLE, RUN, PAUSED, DONE; 2 bits)
  - SEC_W=5
  - MODE_REC=1'b0, MODE_PLAY=1'b1
- Sub-module tick_prescaler:
  - Inputs: i_clk, i_rst, i_en, i_clr.
  - Output: o_tick.
  - Parameter: CLK_HZ.
  - Holds its count while i_en=0.
- record_timer instantiates tick_prescaler and contains the FSM, the seconds counter and the length register.

Test Plan (CLK_HZ=4 in simulation):
- Record 3 s: reset, start with mode=0, wait 12 cycles, stop -> o_sec=3, o_tick pulsed 3 times, o_done one cycle, o_rec_len=3, o_state back to IDLE one cycle later.
- Playback: after the record test, start with mode=1 -> o_sec counts 1,2,3, then o_done fires on the same edge as the third tick; o_rec_len stays 3.
- Pause: record, pause after 6 cycles (o_sec=1, prescaler=2), hold 20 cycles, then resume with start -> next tick comes 2 cycles after resume; o_sec=2.
- Saturation: record with no stop for 200 cycles -> DONE at 128 cycles, o_sec=31, o_rec_len=31, never 0.
- Simultaneous and edge cases:
  - start+stop in the same cycle in RUN -> DONE.
  - Play start with o_rec_len=0 -> o_done on the next edge with o_sec=0.
  - Pause in IDLE -> no state change.
- Async reset mid-RUN with o_sec=5: assert i_rst between clock edges -> o_sec=0, o_rec_len=0, state IDLE immediately, and no o_done pulse.
